// File: rtl/gpio_stim_pkg.sv
// Shared types for the GPIO stimulus sequencer: opcodes, FSM states and the
// packed command record carried through the command FIFO.
package gpio_stim_pkg;

    localparam int unsigned CMD_DLY_W = 16;
    localparam int unsigned CMD_PAD_W = 6;

    typedef enum logic [1:0] {
        OP_DRIVE    = 2'd0,
        OP_RELEASE  = 2'd1,
        OP_WAIT_PIN = 2'd2,
        OP_WAIT_CYC = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_POLL  = 2'd2
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [CMD_PAD_W-1:0] pad;
        logic                 value;
        logic [CMD_DLY_W-1:0] delay;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/gpio_stim_fifo.sv
// Synchronous command FIFO; pointers carry a wrap bit so full and empty are
// told apart without a separate occupancy counter. Flush wins over push.
module gpio_stim_fifo
    import gpio_stim_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    input  logic flush_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/gpio_stim_sequencer.sv
// Timed pad stimulus sequencer: pops queued DRIVE/RELEASE/WAIT_PIN/WAIT_CYC
// commands and applies them to per-pad drive/enable registers.
module gpio_stim_sequencer
    import gpio_stim_pkg::*;
#(
    parameter int unsigned NUM_PADS = 38,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DLY_W    = CMD_DLY_W
) (
    input  logic                 clock,
    input  logic                 reset,
    // A command transfers on a rising edge where cmd_valid && cmd_ready; the
    // fields must be stable while cmd_valid is high, and cmd_ready never
    // depends on cmd_valid.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [5:0]           cmd_pad,
    input  logic                 cmd_value,
    input  logic [DLY_W-1:0]     cmd_delay,
    input  logic [NUM_PADS-1:0]  pad_in,
    output logic [NUM_PADS-1:0]  pad_out,
    output logic [NUM_PADS-1:0]  pad_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_flag,
    output logic                 pad_err,
    output state_e               dbg_state
);

    localparam logic [NUM_PADS-1:0]  PAD_ONE   = {{(NUM_PADS-1){1'b0}}, 1'b1};
    localparam logic [CMD_PAD_W:0]   PAD_LIMIT = (CMD_PAD_W+1)'(NUM_PADS);

    state_e                state_q, state_d;
    cmd_t                  act_q, act_d;
    logic [CMD_DLY_W-1:0]  cnt_q, cnt_d;
    logic [NUM_PADS-1:0]   pad_out_q, pad_out_d;
    logic [NUM_PADS-1:0]   pad_oe_q, pad_oe_d;
    logic                  done_q, done_d;
    logic                  tflag_q, tflag_d;
    logic                  perr_q, perr_d;

    cmd_t                  fifo_wdata;
    cmd_t                  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic [NUM_PADS-1:0]   pad_sel;
    logic                  pad_hit;

    assign fifo_wdata.op    = op_e'(cmd_op);
    assign fifo_wdata.pad   = cmd_pad;
    assign fifo_wdata.value = cmd_value;
    assign fifo_wdata.delay = CMD_DLY_W'(cmd_delay);

    gpio_stim_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The active pad is range-checked at pop time, so the one-hot mask is
    // always inside the pad vector when it is used.
    assign pad_sel = PAD_ONE << act_q.pad;
    assign pad_hit = |(pad_in & pad_sel);

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        cnt_d      = cnt_q;
        pad_out_d  = pad_out_q;
        pad_oe_d   = pad_oe_q;
        done_d     = 1'b0;
        tflag_d    = tflag_q;
        perr_d     = perr_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    act_d    = fifo_head;
                    cnt_d    = fifo_head.delay;
                    if ({1'b0, fifo_head.pad} >= PAD_LIMIT) begin
                        perr_d = 1'b1;
                    end else if (fifo_head.op == OP_WAIT_PIN) begin
                        cnt_d   = '0;
                        state_d = ST_POLL;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
            end

            ST_DELAY: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    case (act_q.op)
                        OP_DRIVE: begin
                            pad_out_d = (pad_out_q & ~pad_sel) |
                                        (act_q.value ? pad_sel : '0);
                            pad_oe_d  = pad_oe_q | pad_sel;
                        end
                        OP_RELEASE: pad_oe_d = pad_oe_q & ~pad_sel;
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_POLL: begin
                // A match on the final sample still counts as success.
                if (pad_hit == act_q.value) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if ((act_q.delay != '0) &&
                             (cnt_q == act_q.delay - CMD_DLY_W'(1))) begin
                    tflag_d    = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            act_q     <= '0;
            cnt_q     <= '0;
            pad_out_q <= '0;
            pad_oe_q  <= '0;
            done_q    <= 1'b0;
            tflag_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            cnt_q     <= cnt_d;
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
            done_q    <= done_d;
            tflag_q   <= tflag_d;
            perr_q    <= perr_d;
        end
    end

    assign cmd_ready    = !fifo_full;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign pad_out      = pad_out_q;
    assign pad_oe       = pad_oe_q;
    assign done         = done_q;
    assign timeout_flag = tflag_q;
    assign pad_err      = perr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_gpio_stim_sequencer.sv
// Directed bench for gpio_stim_sequencer: a table of single commands with
// hand-computed pad images, then hand-written multi-cycle corner sequences.
module tb_gpio_stim_sequencer;
    import gpio_stim_pkg::*;

    localparam int NP = 38;

    logic           clock;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [5:0]     cmd_pad;
    logic           cmd_value;
    logic [15:0]    cmd_delay;
    logic [NP-1:0]  pad_in;
    logic [NP-1:0]  pad_out;
    logic [NP-1:0]  pad_oe;
    logic           busy;
    logic           done;
    logic           timeout_flag;
    logic           pad_err;
    state_e         dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]    op;
        logic [5:0]    pad;
        logic          value;
        logic [15:0]   dly;
        logic [NP-1:0] exp_out;
        logic [NP-1:0] exp_oe;
    } vec_t;

    vec_t vecs [7];

    gpio_stim_sequencer #(
        .NUM_PADS(NP),
        .DEPTH   (8),
        .DLY_W   (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_pad      (cmd_pad),
        .cmd_value    (cmd_value),
        .cmd_delay    (cmd_delay),
        .pad_in       (pad_in),
        .pad_out      (pad_out),
        .pad_oe       (pad_oe),
        .busy         (busy),
        .done         (done),
        .timeout_flag (timeout_flag),
        .pad_err      (pad_err),
        .dbg_state    (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [5:0] pad,
                            input logic val, input logic [15:0] dly);
        int waited;
        waited    = 0;
        cmd_op    = op;
        cmd_pad   = pad;
        cmd_value = val;
        cmd_delay = dly;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL push_accept: cmd_ready stayed %0b expected 1", cmd_ready);
        end else begin
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int dones;
        int busy_bad;
        int not_ready;

        vecs[0] = '{OP_DRIVE,    6'd5,  1'b1, 16'd3, 38'h00_0000_0020, 38'h00_0000_0020};
        vecs[1] = '{OP_DRIVE,    6'd0,  1'b0, 16'd0, 38'h00_0000_0020, 38'h00_0000_0021};
        vecs[2] = '{OP_DRIVE,    6'd37, 1'b1, 16'd1, 38'h20_0000_0020, 38'h20_0000_0021};
        vecs[3] = '{OP_RELEASE,  6'd5,  1'b0, 16'd2, 38'h20_0000_0020, 38'h20_0000_0001};
        vecs[4] = '{OP_WAIT_CYC, 6'd9,  1'b1, 16'd4, 38'h20_0000_0020, 38'h20_0000_0001};
        vecs[5] = '{OP_RELEASE,  6'd0,  1'b1, 16'd0, 38'h20_0000_0020, 38'h20_0000_0000};
        vecs[6] = '{OP_DRIVE,    6'd5,  1'b0, 16'd1, 38'h20_0000_0000, 38'h20_0000_0020};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_pad   = 6'd0;
        cmd_value = 1'b0;
        cmd_delay = 16'd0;
        pad_in    = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_pad_out",   pad_out, 0);
        check("rst_pad_oe",    pad_oe, 0);
        check("rst_done",      done, 0);
        check("rst_tflag",     timeout_flag, 0);
        check("rst_pad_err",   pad_err, 0);
        check("rst_busy",      busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_state",     dbg_state, ST_IDLE);

        // Single commands: done appears delay+2 edges after the accept edge.
        for (int v = 0; v < 7; v++) begin
            push_cmd(vecs[v].op, vecs[v].pad, vecs[v].value, vecs[v].dly);
            wait_done(200, n);
            check($sformatf("vec%0d_latency", v), n, int'(vecs[v].dly) + 2);
            check($sformatf("vec%0d_pad_out", v), pad_out, vecs[v].exp_out);
            check($sformatf("vec%0d_pad_oe", v), pad_oe, vecs[v].exp_oe);
            step();
            check($sformatf("vec%0d_done_pulse", v), done, 0);
        end

        // Fill: a long WAIT_CYC occupies the FSM while eight more fill the FIFO.
        push_cmd(OP_WAIT_CYC, 6'd0, 1'b0, 16'd40);
        for (int k = 0; k < 8; k++) push_cmd(OP_WAIT_CYC, 6'd0, 1'b0, 16'd10);
        check("fill_ready_low", cmd_ready, 0);
        cmd_op    = OP_DRIVE;
        cmd_pad   = 6'd20;
        cmd_value = 1'b1;
        cmd_delay = 16'd0;
        cmd_valid = 1'b1;
        not_ready = 0;
        for (int k = 0; k < 5; k++) begin
            if (!cmd_ready) not_ready++;
            step();
        end
        cmd_valid = 1'b0;
        check("fill_9th_refused", not_ready, 5);
        wait_done(100, n);
        check("fill_blocker_done", n > 0, 1);
        check("fill_ready_before_pop", cmd_ready, 0);
        step();
        check("fill_ready_after_pop", cmd_ready, 1);
        dones    = 0;
        busy_bad = 0;
        for (int i = 0; i < 200 && dones < 8; i++) begin
            if (done) dones++;
            if (dones < 8 && !busy) busy_bad++;
            if (dones < 8) step();
        end
        check("fill_dones", dones, 8);
        check("fill_busy_held", busy_bad, 0);
        check("fill_busy_end", busy, 0);
        check("fill_no_9th_effect", pad_oe[20], 0);

        // WAIT_PIN satisfied seven cycles after the pop.
        push_cmd(OP_WAIT_PIN, 6'd12, 1'b1, 16'd20);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                n = i;
                break;
            end
            if (i == 8) pad_in[12] = 1'b1;
        end
        check("wp_match_latency", n, 9);
        check("wp_match_tflag", timeout_flag, 0);
        pad_in = '0;
        step();

        // WAIT_PIN timeout of 4 with three DRIVEs queued behind it.
        push_cmd(OP_WAIT_PIN, 6'd12, 1'b1, 16'd4);
        push_cmd(OP_DRIVE, 6'd1, 1'b1, 16'd0);
        push_cmd(OP_DRIVE, 6'd2, 1'b1, 16'd0);
        push_cmd(OP_DRIVE, 6'd3, 1'b1, 16'd0);
        check("to_not_early", timeout_flag, 0);
        n     = -1;
        dones = 0;
        for (int i = 4; i <= 20; i++) begin
            step();
            if (done) dones++;
            if (timeout_flag && n < 0) n = i;
        end
        check("to_flag_edge", n, 5);
        check("to_no_done", dones, 0);
        check("to_fifo_empty", busy, 0);
        check("to_ready", cmd_ready, 1);
        check("to_pad_oe", pad_oe, 38'h20_0000_0020);
        check("to_pad_out", pad_out, 38'h20_0000_0000);

        // Out-of-range pad is discarded; the next command runs normally.
        push_cmd(OP_DRIVE, 6'd40, 1'b1, 16'd0);
        push_cmd(OP_DRIVE, 6'd0, 1'b1, 16'd0);
        check("perr_set", pad_err, 1);
        wait_done(50, n);
        check("perr_next_latency", n, 2);
        check("perr_pad_out", pad_out, 38'h20_0000_0001);
        check("perr_pad_oe", pad_oe, 38'h20_0000_0021);
        check("perr_tflag_sticky", timeout_flag, 1);

        // Reset during the DELAY of a RELEASE with two DRIVEs queued.
        push_cmd(OP_RELEASE, 6'd37, 1'b0, 16'd20);
        push_cmd(OP_DRIVE, 6'd10, 1'b1, 16'd0);
        push_cmd(OP_DRIVE, 6'd11, 1'b1, 16'd0);
        step();
        step();
        check("rst2_pre_oe37", pad_oe[37], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_pad_out", pad_out, 0);
        check("rst2_pad_oe", pad_oe, 0);
        check("rst2_done", done, 0);
        check("rst2_tflag", timeout_flag, 0);
        check("rst2_pad_err", pad_err, 0);
        check("rst2_busy", busy, 0);
        check("rst2_ready", cmd_ready, 1);
        check("rst2_state", dbg_state, ST_IDLE);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dones++;
        end
        check("rst2_no_done", dones, 0);
        check("rst2_pad_oe_after", pad_oe, 0);
        check("rst2_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_stim_sequencer.md
# gpio_stim_sequencer

Hardware sequencer for the 38 user-project I/O pads in the cocotb chip-level bench. Executes a queued list of timed commands that drive, release or poll individual pads. Cocotb no longer needs to toggle per-pad drive/enable wires cycle by cycle. Sits between the bench control layer (command writer) and the per-pad drive/enable/monitor nets around the chip under test.

## Interface
- NUM_PADS, 38, number of controlled pads (44 for the openframe build)
- DEPTH, 8, command FIFO entries (power of two)
- DLY_W, 16, width of the delay/timeout field
- clock  in  1  bench clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock of assertion is sufficient
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full; a command is accepted on an edge with cmd_valid & cmd_ready
- cmd_op  in  2  0 DRIVE, 1 RELEASE, 2 WAIT_PIN, 3 WAIT_CYC
- cmd_pad  in  6  target pad index
- cmd_value  in  1  drive level (DRIVE) or expected level (WAIT_PIN)
- cmd_delay  in  DLY_W  pre-delay cycles (DRIVE/RELEASE/WAIT_CYC) or timeout (WAIT_PIN, 0 = none)
- pad_in  in  NUM_PADS  sampled pad levels (monitor nets)
- pad_out  out  NUM_PADS  per-pad drive value
- pad_oe  out  NUM_PADS  per-pad drive enable; 0 = pad released to z
- busy  out  1  FSM not IDLE or FIFO not empty
- done  out  1  one-cycle pulse on command completion
- timeout_flag  out  1  sticky; a WAIT_PIN timed out
- pad_err  out  1  sticky; a command with cmd_pad >= NUM_PADS was popped

## Operation
- Commands are stored in order in a DEPTH-entry FIFO. There is no bypass: a command written into an empty FIFO is popped on the following edge.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head and load the active registers and cnt <= cmd_delay.
    - Pad out of range: set pad_err, discard the command, no done pulse, stay IDLE.
    - WAIT_PIN: go to POLL, cnt <= 0.
    - All other ops: go to DELAY.
  - DELAY: if cnt == 0, apply the effect and pulse done, then go to IDLE; else cnt <= cnt-1.
    - DRIVE effect: pad_out[pad] <= value, pad_oe[pad] <= 1.
    - RELEASE effect: pad_oe[pad] <= 0; pad_out is unchanged.
    - WAIT_CYC: no pad effect.
  - POLL: each cycle, compare pad_in[pad] with value.
    - Match: pulse done, go to IDLE.
    - No match, timeout nonzero and cnt == timeout-1: set timeout_flag, flush the FIFO, go to IDLE, no done pulse.
    - Otherwise: cnt <= cnt+1.
- Match has priority over timeout in the same cycle.
- Only the addressed bit of pad_out/pad_oe changes. All other bits hold.
- cmd_ready depends only on registered FIFO fullness. A full FIFO refuses a push even on a cycle where IDLE pops.
- A push and a pop in the same cycle on a non-full, non-empty FIFO are both performed; occupancy is unchanged.
- Flush on timeout empties the FIFO. A push accepted on the flush edge is also discarded.
- timeout_flag and pad_err clear only on reset.

## Timing
- Reset values: pad_out = 0, pad_oe = 0, done = 0, timeout_flag = 0, pad_err = 0, busy = 0, cmd_ready = 1, FIFO empty, FSM IDLE.
- Command accepted at edge W (FIFO previously empty, FSM IDLE): popped at W+1.
- DRIVE/RELEASE/WAIT_CYC with delay d: effect and done visible after edge W+d+2.
- WAIT_PIN: pad_in is sampled from edge W+2 onward. With a match already present, done is visible after W+2.
- WAIT_PIN with timeout t and no match: timeout_flag visible after edge W+t+1; exactly t samples are taken.
- Throughput: at most one command per 2 cycles, because IDLE is re-entered between commands.
- Reset asserted mid-command: on that edge the active command and all queued commands are abandoned and every output returns to its reset value.

## Structure
- Package gpio_stim_pkg holds:
  - op encoding constants OP_DRIVE/OP_RELEASE/OP_WAIT_PIN/OP_WAIT_CYC
  - FSM state encoding
  - packed command struct (op, pad, value, delay) and its width
- Sub-module gpio_stim_fifo: synchronous FIFO of the command struct.
  - Parameter DEPTH; ports push, pop, flush, full, empty.
  - Pointers carry an extra wrap bit.
- The top holds the FSM, the counter and the pad registers.

## Test plan
- Reset then DRIVE pad 5 value 1 delay 3, accepted at edge 0 -> pad_oe[5] = 1 and pad_out[5] = 1 after edge 5, done pulse on edge 5, all other bits 0.
- Fill the FIFO with 8 WAIT_CYC delay 10 -> cmd_ready = 0 after the 8th accept; a 9th cmd_valid is not accepted; ready returns after the first pop; busy stays 1 until the last done.
- WAIT_PIN pad 12 value 1 timeout 20; bench raises pad_in[12] 7 cycles after the pop -> done pulse, timeout_flag = 0.
- WAIT_PIN pad 12 value 1 timeout 4 with 3 DRIVEs queued behind it; pad_in stays 0 -> timeout_flag = 1 after 4 samples, FIFO empty, no DRIVE applied.
- DRIVE pad 40 (NUM_PADS = 38) then DRIVE pad 0 value 1 delay 0 -> pad_err = 1, no pad change for pad 40, pad 0 driven.
- Assert reset during the DELAY of a RELEASE with two commands queued -> all outputs at reset values next cycle, FIFO empty, no done.
